// File: rtl/wt_cache_pkg.sv
// wt_cache_pkg -- shared types for the write-through cache write buffer.
//
// Contents:
//   WBUF_PLEN/XLEN/BE_W : field widths of a buffered store (Sv32 physical
//                         address, 32-bit data). wt_wbuf defaults to these,
//                         and its entry storage uses them, so a different
//                         PLEN/XLEN is made by changing these values.
//   wbuf_state_e        : per-entry lifecycle FREE -> PEND -> INFL -> FREE.
//   wbuf_entry_t        : buffered store payload (word address, data, byte enables).
//   wbuf_merge_bytes    : byte-lane overwrite used when a store is merged.
package wt_cache_pkg;

  localparam int unsigned WBUF_PLEN = 34;
  localparam int unsigned WBUF_XLEN = 32;
  localparam int unsigned WBUF_BE_W = WBUF_XLEN / 8;

  typedef enum logic [1:0] {
    WBUF_FREE = 2'd0,  // slot available for allocation
    WBUF_PEND = 2'd1,  // holds a store not yet granted by memory
    WBUF_INFL = 2'd2   // granted, waiting for the write acknowledge
  } wbuf_state_e;

  typedef struct packed {
    logic [WBUF_PLEN-1:0] addr;  // word-aligned byte address
    logic [WBUF_XLEN-1:0] data;
    logic [WBUF_BE_W-1:0] be;
  } wbuf_entry_t;

  // Replace the byte lanes of old_data selected by be with new_data.
  function automatic logic [WBUF_XLEN-1:0] wbuf_merge_bytes(
    input logic [WBUF_XLEN-1:0] old_data,
    input logic [WBUF_XLEN-1:0] new_data,
    input logic [WBUF_BE_W-1:0] be
  );
    logic [WBUF_XLEN-1:0] res;
    res = old_data;
    for (int b = 0; b < int'(WBUF_BE_W); b++) begin
      if (be[b]) res[b*8 +: 8] = new_data[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wbuf_order_fifo.sv
// wbuf_order_fifo -- drain-order FIFO of write-buffer entry indices.
//
// Holds the indices of PEND entries in allocation order; the head is the
// entry presented to memory. It never holds more than DEPTH indices because
// every pushed index names a distinct buffer entry.
//
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   push_i          : append push_idx_i
//   push_idx_i      : entry index to append
//   pop_i           : drop the head (only while not empty)
//   head_o          : oldest stored index
//   empty_o         : no index stored
module wbuf_order_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [IDX_W-1:0] push_idx_i,
  input  logic             pop_i,
  output logic [IDX_W-1:0] head_o,
  output logic             empty_o
);

  logic [IDX_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] wr_ptr_q;
  logic [IDX_W-1:0] rd_ptr_q;
  logic [IDX_W:0]   cnt_q;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_idx_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/wt_wbuf.sv
// wt_wbuf -- write buffer between the store unit and the memory adapter.
//
// Stores are merged into a waiting (not yet presented) entry to the same word
// or allocated into the lowest free entry, then drained oldest-first. An entry
// is PEND until granted, INFL until its write is acknowledged, then FREE.
//
// Ports:
//   clk_i, rst_ni                     : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o           : store handshake
//   req_addr_i/req_data_i/req_be_i    : store byte address, lane-aligned data, byte enables
//   mem_req_o/mem_gnt_i               : write request handshake to memory
//   mem_addr_o/data_o/be_o/tid_o      : presented write (tid = entry index), zero when idle
//   mem_ack_i/mem_ack_tid_i           : write completion for entry mem_ack_tid_i
//   rd_paddr_i/rd_hit_o               : load query, pending or in-flight write to that word
//   empty_o/full_o                    : all entries free / no entry free
module wt_wbuf
  import wt_cache_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PLEN  = WBUF_PLEN,
  parameter int unsigned XLEN  = WBUF_XLEN,
  parameter int unsigned BE_W  = XLEN / 8,
  parameter int unsigned TID_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [PLEN-1:0]  req_addr_i,
  input  logic [XLEN-1:0]  req_data_i,
  input  logic [BE_W-1:0]  req_be_i,
  output logic             mem_req_o,
  input  logic             mem_gnt_i,
  output logic [PLEN-1:0]  mem_addr_o,
  output logic [XLEN-1:0]  mem_data_o,
  output logic [BE_W-1:0]  mem_be_o,
  output logic [TID_W-1:0] mem_tid_o,
  input  logic             mem_ack_i,
  input  logic [TID_W-1:0] mem_ack_tid_i,
  input  logic [PLEN-1:0]  rd_paddr_i,
  output logic             rd_hit_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned OFF   = $clog2(BE_W);

  wbuf_state_e state_q [DEPTH];
  wbuf_entry_t ent_q   [DEPTH];

  logic [IDX_W-1:0] head_idx;
  logic             fifo_empty;
  logic [IDX_W-1:0] alloc_idx;
  logic [IDX_W-1:0] merge_idx;
  logic             merge_hit;
  logic             free_any;
  logic             accept;
  logic             grant;
  logic             alloc;
  wbuf_entry_t      new_ent;
  wbuf_entry_t      head_ent;

  logic [DEPTH-1:0] is_free;
  logic [DEPTH-1:0] merge_match;
  logic [DEPTH-1:0] rd_match;
  logic [DEPTH-1:0] ack_sel;
  logic [DEPTH-1:0] grant_sel;

  // Address offset bits inside a word never take part in matching.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{req_addr_i[OFF-1:0], rd_paddr_i[OFF-1:0]};

  for (genvar gi = 0; gi < int'(DEPTH); gi++) begin : g_entry
    assign is_free[gi] = (state_q[gi] == WBUF_FREE);
    // The presented entry is excluded so its payload stays stable until grant.
    assign merge_match[gi] = (state_q[gi] == WBUF_PEND)
                          && (ent_q[gi].addr[PLEN-1:OFF] == req_addr_i[PLEN-1:OFF])
                          && !(mem_req_o && (head_idx == IDX_W'(gi)));
    assign rd_match[gi]  = (state_q[gi] != WBUF_FREE)
                        && (ent_q[gi].addr[PLEN-1:OFF] == rd_paddr_i[PLEN-1:OFF]);
    // Acks naming an entry that is not in flight (e.g. left over from before
    // a reset) are dropped here.
    assign ack_sel[gi]   = mem_ack_i && (mem_ack_tid_i == TID_W'(gi))
                        && (state_q[gi] == WBUF_INFL);
    assign grant_sel[gi] = grant && (head_idx == IDX_W'(gi));
  end

  // Lowest-index priority encoders for allocation and merging.
  always_comb begin
    alloc_idx = '0;
    merge_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (is_free[i])     alloc_idx = IDX_W'(i);
      if (merge_match[i]) merge_idx = IDX_W'(i);
    end
  end

  assign free_any  = |is_free;
  assign merge_hit = |merge_match;
  // Ready comes from registered state only; a same-cycle ack cannot open a slot.
  assign req_ready_o = merge_hit || free_any;
  assign accept      = req_valid_i && req_ready_o;
  assign alloc       = accept && !merge_hit;
  assign grant       = mem_req_o && mem_gnt_i;

  always_comb begin
    new_ent      = '0;
    new_ent.addr = {req_addr_i[PLEN-1:OFF], {OFF{1'b0}}};
    new_ent.data = wbuf_merge_bytes('0, req_data_i, req_be_i);
    new_ent.be   = req_be_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        state_q[i] <= WBUF_FREE;
        ent_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (ack_sel[i]) begin
          state_q[i] <= WBUF_FREE;
        end else if (grant_sel[i]) begin
          state_q[i] <= WBUF_INFL;
        end else if (alloc && (alloc_idx == IDX_W'(i))) begin
          state_q[i] <= WBUF_PEND;
          ent_q[i]   <= new_ent;
        end
        if (accept && merge_hit && (merge_idx == IDX_W'(i))) begin
          ent_q[i].data <= wbuf_merge_bytes(ent_q[i].data, req_data_i, req_be_i);
          ent_q[i].be   <= ent_q[i].be | req_be_i;
        end
      end
    end
  end

  wbuf_order_fifo #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_order_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (alloc),
    .push_idx_i (alloc_idx),
    .pop_i      (grant),
    .head_o     (head_idx),
    .empty_o    (fifo_empty)
  );

  assign head_ent   = ent_q[head_idx];
  assign mem_req_o  = !fifo_empty;
  assign mem_addr_o = mem_req_o ? head_ent.addr : '0;
  assign mem_data_o = mem_req_o ? head_ent.data : '0;
  assign mem_be_o   = mem_req_o ? head_ent.be   : '0;
  assign mem_tid_o  = mem_req_o ? TID_W'(head_idx) : '0;

  assign rd_hit_o = |rd_match;
  assign empty_o  = &is_free;
  assign full_o   = !free_any;

endmodule

// File: tb/tb_wt_wbuf.sv
module tb_wt_wbuf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [33:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_be = '0;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic [33:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic [1:0]  mem_tid;
  logic        mem_ack = 1'b0;
  logic [1:0]  mem_ack_tid = '0;
  logic [33:0] rd_paddr = '0;
  logic        rd_hit;
  logic        empty;
  logic        full;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [33:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [1:0]  tid;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  wt_wbuf dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_addr_i    (req_addr),
    .req_data_i    (req_data),
    .req_be_i      (req_be),
    .mem_req_o     (mem_req),
    .mem_gnt_i     (mem_gnt),
    .mem_addr_o    (mem_addr),
    .mem_data_o    (mem_data),
    .mem_be_o      (mem_be),
    .mem_tid_o     (mem_tid),
    .mem_ack_i     (mem_ack),
    .mem_ack_tid_i (mem_ack_tid),
    .rd_paddr_i    (rd_paddr),
    .rd_hit_o      (rd_hit),
    .empty_o       (empty),
    .full_o        (full)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic expect_wr(input logic [33:0] a, input logic [31:0] d,
                           input logic [3:0] b, input logic [1:0] t);
    exp_t e;
    e.addr = a; e.data = d; e.be = b; e.tid = t;
    exp_q.push_back(e);
  endtask

  // Monitor: every granted write is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && mem_req && mem_gnt) begin
      $display("MEM_WR tid=%0d addr=%0h data=%08h be=%0h", mem_tid, mem_addr, mem_data, mem_be);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(mem_addr), 64'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e.addr));
        check("wr_data", 64'(mem_data), 64'(e.data));
        check("wr_be",   64'(mem_be),   64'(e.be));
        check("wr_tid",  64'(mem_tid),  64'(e.tid));
      end
    end
  end

  task automatic do_store(input logic [33:0] a, input logic [31:0] d, input logic [3:0] b);
    bit done;
    done = 1'b0;
    req_valid = 1'b1; req_addr = a; req_data = d; req_be = b;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    $display("STORE addr=%0h data=%08h be=%0h accepted=%0d", a, d, b, done);
    if (!done) check("store_timeout", 64'd0, 64'd1);
  endtask

  task automatic grant_one();
    bit seen;
    seen = 1'b0;
    mem_gnt = 1'b1;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    if (!seen) check("grant_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    mem_gnt = 1'b0;
  endtask

  task automatic do_ack(input logic [1:0] t);
    mem_ack = 1'b1; mem_ack_tid = t;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    $display("ACK tid=%0d", t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_ready",   64'(req_ready), 64'd1);
    check("rst_empty",   64'(empty), 64'd1);
    check("rst_full",    64'(full), 64'd0);
    check("rst_rd_hit",  64'(rd_hit), 64'd0);
    check("rst_payload", {mem_addr, mem_data}, 64'd0);
    check("rst_be_tid",  {mem_be, mem_tid}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single store, granted in its first presented cycle, then acked
    expect_wr(34'h0_8000_0000, 32'h1122_3344, 4'hF, 2'd0);
    do_store(34'h0_8000_0000, 32'h1122_3344, 4'hF);
    grant_one();
    @(negedge clk);
    check("t1_req_after_gnt", 64'(mem_req), 64'd0);
    check("t1_not_empty",     64'(empty), 64'd0);
    @(posedge clk); #1;
    do_ack(2'd0);
    @(negedge clk);
    check("t1_empty_after_ack", 64'(empty), 64'd1);
    @(posedge clk); #1;

    // Merge into a waiting entry behind the presented one
    expect_wr(34'h0_8000_0010, 32'hDEAD_BEEF, 4'hF, 2'd0);
    expect_wr(34'h0_8000_0004, 32'h0000_BBAA, 4'h3, 2'd1);
    do_store(34'h0_8000_0010, 32'hDEAD_BEEF, 4'hF);
    do_store(34'h0_8000_0004, 32'h0000_00AA, 4'h1);
    @(negedge clk);
    check("t2_full_before_merge", 64'(full), 64'd1);
    @(posedge clk); #1;
    do_store(34'h0_8000_0006, 32'h0000_BB00, 4'h2);
    grant_one();
    grant_one();
    do_ack(2'd0);
    do_ack(2'd1);
    @(negedge clk);
    check("t2_empty", 64'(empty), 64'd1);
    @(posedge clk); #1;

    // Same word as the presented entry: no merge, a second entry is used
    expect_wr(34'h0_8000_0030, 32'h0000_0011, 4'h1, 2'd0);
    expect_wr(34'h0_8000_0030, 32'h0000_2200, 4'h2, 2'd1);
    do_store(34'h0_8000_0030, 32'h0000_0011, 4'h1);
    do_store(34'h0_8000_0031, 32'h0000_2200, 4'h2);
    @(negedge clk);
    check("t3_full_no_merge", 64'(full), 64'd1);
    @(posedge clk); #1;
    grant_one();
    grant_one();
    do_ack(2'd1);
    do_ack(2'd0);

    // Full stall, then ack with a store waiting in the same cycle
    expect_wr(34'h0_8000_0020, 32'h0000_0020, 4'hF, 2'd0);
    expect_wr(34'h0_8000_0024, 32'h0000_0024, 4'hF, 2'd1);
    expect_wr(34'h0_8000_0028, 32'h0000_0028, 4'hF, 2'd0);
    do_store(34'h0_8000_0020, 32'h0000_0020, 4'hF);
    do_store(34'h0_8000_0024, 32'h0000_0024, 4'hF);
    req_valid = 1'b1; req_addr = 34'h0_8000_0028; req_data = 32'h0000_0028; req_be = 4'hF;
    @(negedge clk);
    check("t4_stall_ready", 64'(req_ready), 64'd0);
    check("t4_stall_full",  64'(full), 64'd1);
    @(posedge clk); #1;
    grant_one();
    @(negedge clk);
    check("t4_ready_infl", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_ack_tid = 2'd0;
    @(negedge clk);
    check("t4_ready_ack_cycle", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("t4_ready_after_ack", 64'(req_ready), 64'd1);
    check("t4_not_full",        64'(full), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("t4_full_again", 64'(full), 64'd1);
    @(posedge clk); #1;
    grant_one();
    grant_one();
    do_ack(2'd1);
    do_ack(2'd0);
    @(negedge clk);
    check("t4_empty", 64'(empty), 64'd1);
    @(posedge clk); #1;

    // Load-hit query against pending and in-flight entries
    expect_wr(34'h0_8000_0008, 32'hCAFE_F00D, 4'hF, 2'd0);
    rd_paddr = 34'h0_8000_0008;
    do_store(34'h0_8000_0008, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    check("t5_hit_pend", 64'(rd_hit), 64'd1);
    @(posedge clk); #1;
    grant_one();
    @(negedge clk);
    check("t5_hit_infl", 64'(rd_hit), 64'd1);
    rd_paddr = 34'h0_8000_000B;
    #1 check("t5_hit_same_word", 64'(rd_hit), 64'd1);
    rd_paddr = 34'h0_8000_000C;
    #1 check("t5_miss_next_word", 64'(rd_hit), 64'd0);
    rd_paddr = 34'h0_8000_0008;
    @(posedge clk); #1;
    do_ack(2'd0);
    @(negedge clk);
    check("t5_hit_after_ack", 64'(rd_hit), 64'd0);
    @(posedge clk); #1;

    // Reset with two writes in flight, then a stale ack
    expect_wr(34'h0_8000_0040, 32'h0000_0040, 4'hF, 2'd0);
    expect_wr(34'h0_8000_0044, 32'h0000_0044, 4'hF, 2'd1);
    do_store(34'h0_8000_0040, 32'h0000_0040, 4'hF);
    do_store(34'h0_8000_0044, 32'h0000_0044, 4'hF);
    grant_one();
    grant_one();
    @(negedge clk);
    check("t6_full_infl", 64'(full), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_empty", 64'(empty), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_ack(2'd1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("t6_empty_after_stale_ack", 64'(empty), 64'd1);
      check("t6_no_mem_req", 64'(mem_req), 64'd0);
    end
    @(posedge clk); #1;

    check("pending_expectations", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
